// File: rtl/fault_inject_00_if.sv
// Stream bundle for fault_inject_00: upstream (s_*) and downstream (m_*) valid/ready channels.
// The slave modport is the injector's view; master is the environment's view.
interface fault_inject_00_if #(
   parameter int DATA_W = 32
) ();
   logic              s_valid;
   logic              s_ready;
   logic [DATA_W-1:0] s_data;
   logic              m_valid;
   logic              m_ready;
   logic              m_fault;
   logic [DATA_W-1:0] m_data;

   modport master (
      output s_valid, s_data, m_ready,
      input  s_ready, m_valid, m_data, m_fault
   );

   modport slave (
      input  s_valid, s_data, m_ready,
      output s_ready, m_valid, m_data, m_fault
   );
endinterface

// File: rtl/fault_inject_00.sv
// Inline stream fault injector: XORs LFSR-derived flip patterns into beats at a programmable rate.
// Optional macro FAULT_INJ_ONESHOT_EN adds i_inj_oneshot for a single forced injection.
module fault_inject_00 #(
   parameter int DATA_W   = 32,
   parameter int PERIOD_W = 16
) (
   input  logic                clk,
   input  logic                rst,
   fault_inject_00_if.slave    bus,
   input  logic                i_inj_enable,
   input  logic [1:0]          i_inj_mode,
   input  logic [PERIOD_W-1:0] i_inj_period,
   input  logic [31:0]         i_lfsr_mask,
`ifdef FAULT_INJ_ONESHOT_EN
   input  logic                i_inj_oneshot,
`endif
   output logic [31:0]         o_fault_count
);
   localparam int IDX_W = $clog2(DATA_W);

   typedef enum logic [1:0] {
      MODE_PASS   = 2'd0,
      MODE_SINGLE = 2'd1,
      MODE_DOUBLE = 2'd2,
      MODE_FULL   = 2'd3
   } mode_e;

   logic                r_valid;
   logic                r_fault;
   logic [DATA_W-1:0]   r_data;
   logic [PERIOD_W-1:0] r_cnt;
   logic [31:0]         r_fault_count;

   mode_e               w_mode;
   logic                w_accept;
   logic                w_armed;
   logic                w_oneshot_hit;
   logic                w_inject;
   logic [IDX_W-1:0]    w_idx;
   logic [IDX_W-1:0]    w_idx_nxt;
   logic [DATA_W-1:0]   w_mask;

   assign w_mode      = mode_e'(i_inj_mode);
   assign bus.s_ready = !r_valid || bus.m_ready;
   assign w_accept    = bus.s_valid && bus.s_ready;
   assign w_armed     = i_inj_enable && (w_mode != MODE_PASS);

   // Natural IDX_W-bit wrap gives the (idx + 1) mod DATA_W neighbour for the double flip.
   assign w_idx     = i_lfsr_mask[IDX_W-1:0];
   assign w_idx_nxt = w_idx + IDX_W'(1);

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      w_mask = '0;
      case (w_mode)
         MODE_SINGLE: w_mask = DATA_W'(1) << w_idx;
         MODE_DOUBLE: w_mask = (DATA_W'(1) << w_idx) | (DATA_W'(1) << w_idx_nxt);
         MODE_FULL:   w_mask = i_lfsr_mask[DATA_W-1:0];
         default:     w_mask = '0;
      endcase
   end

`ifdef FAULT_INJ_ONESHOT_EN
   logic r_pending;

   // A pulse coinciding with an accept applies to that beat; otherwise it waits in r_pending.
   assign w_oneshot_hit = (r_pending || i_inj_oneshot) && (w_mode != MODE_PASS);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pending <= 1'b0;
      end else begin
         r_pending <= (r_pending || i_inj_oneshot) && !(w_accept && (w_mode != MODE_PASS));
      end
   end
`else
   assign w_oneshot_hit = 1'b0;
`endif

   assign w_inject = w_accept && ((w_armed && (r_cnt == '0)) || w_oneshot_hit);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid       <= 1'b0;
         r_data        <= '0;
         r_fault       <= 1'b0;
         r_fault_count <= '0;
         r_cnt         <= i_inj_period;
      end else begin
         if (!w_armed) begin
            r_cnt <= i_inj_period;
         end else if (w_accept) begin
            r_cnt <= (r_cnt == '0) ? i_inj_period : r_cnt - PERIOD_W'(1);
         end

         if (w_accept) begin
            r_valid <= 1'b1;
            r_data  <= w_inject ? (bus.s_data ^ w_mask) : bus.s_data;
            r_fault <= w_inject;
         end else if (bus.m_ready) begin
            r_valid <= 1'b0;
         end

         if (w_inject && (r_fault_count != 32'hFFFF_FFFF)) begin
            r_fault_count <= r_fault_count + 32'd1;
         end
      end
   end

   assign bus.m_valid    = r_valid;
   assign bus.m_data     = r_data;
   assign bus.m_fault    = r_fault;
   assign o_fault_count  = r_fault_count;
endmodule

// File: tb/tb_fault_inject_00.sv
// Self-checking bench for fault_inject_00: directed scenarios plus randomized traffic
// against a behavioural model derived from the injection rules.
module tb_fault_inject_00;
   localparam int DATA_W   = 32;
   localparam int PERIOD_W = 16;
`ifdef FAULT_INJ_ONESHOT_EN
   localparam bit HAS_OS = 1'b1;
`else
   localparam bit HAS_OS = 1'b0;
`endif

   typedef struct {
      logic        rdy_exp;
      logic        rdy_got;
      logic        v;
      logic        f;
      logic [31:0] d;
      logic [31:0] fc;
   } exp_t;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic                en = 1'b0;
   logic                oneshot = 1'b0;
   logic [1:0]          mode = 2'd0;
   logic [PERIOD_W-1:0] period = '0;
   logic [31:0]         lfsr = '0;
   logic [31:0]         o_fault_count;

   int n_vec  = 0;
   int n_miss = 0;

   // behavioural model state
   bit          mv, mf, pend;
   logic [31:0] md, fc;
   int          cnt;

   fault_inject_00_if #(.DATA_W(DATA_W)) bus ();

   fault_inject_00 #(.DATA_W(DATA_W), .PERIOD_W(PERIOD_W)) dut (
      .clk           (clk),
      .rst           (rst),
      .bus           (bus.slave),
      .i_inj_enable  (en),
      .i_inj_mode    (mode),
      .i_inj_period  (period),
      .i_lfsr_mask   (lfsr),
`ifdef FAULT_INJ_ONESHOT_EN
      .i_inj_oneshot (oneshot),
`endif
      .o_fault_count (o_fault_count)
   );

   initial forever #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit expired");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] model_mask(input int m, input logic [31:0] l);
      int idx;
      idx = int'(l % 32);
      case (m)
         1:       return 32'h1 << idx;
         2:       return (32'h1 << idx) | (32'h1 << ((idx + 1) % 32));
         3:       return l;
         default: return 32'h0;
      endcase
   endfunction

   task automatic model_edge(input bit rdy);
      bit acc, armed, os, inj;
      if (rst) begin
         mv = 0; mf = 0; md = '0; fc = '0; pend = 0; cnt = int'(period);
         return;
      end
      acc   = bus.s_valid && rdy;
      armed = en && (mode != 0);
      os    = HAS_OS && (pend || oneshot) && (mode != 0);
      inj   = acc && ((armed && cnt == 0) || os);
      if (HAS_OS) pend = (pend || oneshot) && !(acc && mode != 0);
      if (!armed)    cnt = int'(period);
      else if (acc)  cnt = (cnt == 0) ? int'(period) : cnt - 1;
      if (acc) begin
         md = inj ? (bus.s_data ^ model_mask(int'(mode), lfsr)) : bus.s_data;
         mf = inj;
         mv = 1;
      end else if (bus.m_ready) begin
         mv = 0;
      end
      if (inj && fc != 32'hFFFF_FFFF) fc = fc + 1;
   endtask

   // Advance one clock: inputs are already driven at the falling edge.
   task automatic step(output exp_t e);
      e.rdy_exp = !mv || bus.m_ready;
      #1 e.rdy_got = bus.s_ready;
      model_edge(e.rdy_exp);
      @(posedge clk);
      @(negedge clk);
      e.v = mv; e.f = mf; e.d = md; e.fc = fc;
   endtask

   task automatic test_reset();
      exp_t e;
      rst = 1'b1;
      bus.s_valid = 1'b0; bus.s_data = '0; bus.m_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      mv = 0; mf = 0; md = '0; fc = '0; pend = 0; cnt = int'(period);
      step(e);
      rst = 1'b0;
      step(e);
      n_vec++;
      if ({bus.m_valid, bus.m_fault, o_fault_count, bus.s_ready} !== {1'b0, 1'b0, 32'h0, 1'b1}) begin
         n_miss++;
         $display("FAIL reset: got v=%b f=%b cnt=%h rdy=%b, want v=0 f=0 cnt=0 rdy=1",
                  bus.m_valid, bus.m_fault, o_fault_count, bus.s_ready);
      end
   endtask

   task automatic test_passthrough();
      exp_t e;
      en = 1'b1; mode = 2'd0; period = '0; bus.m_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         bus.s_valid = 1'b1; bus.s_data = 32'(k); lfsr = $urandom;
         step(e);
         n_vec++;
         if ({bus.m_valid, bus.m_fault, bus.m_data, o_fault_count} !== {1'b1, 1'b0, 32'(k), 32'h0}) begin
            n_miss++;
            $display("FAIL passthrough[%0d]: got v=%b f=%b d=%h cnt=%h, want v=1 f=0 d=%h cnt=0",
                     k, bus.m_valid, bus.m_fault, bus.m_data, o_fault_count, 32'(k));
         end
      end
      bus.s_valid = 1'b0;
      step(e);
   endtask

   task automatic test_period();
      exp_t        e;
      logic [31:0] want_d;
      logic        want_f;
      en = 1'b1; mode = 2'd1; period = 16'd2; lfsr = 32'h0000_0003; bus.m_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         bus.s_valid = 1'b1; bus.s_data = '0;
         step(e);
         want_f = (k == 0) || (k == 3);
         want_d = want_f ? 32'h0000_0008 : 32'h0;
         n_vec++;
         if ({bus.m_valid, bus.m_fault, bus.m_data} !== {1'b1, want_f, want_d}) begin
            n_miss++;
            $display("FAIL period[%0d]: got v=%b f=%b d=%h, want v=1 f=%b d=%h",
                     k, bus.m_valid, bus.m_fault, bus.m_data, want_f, want_d);
         end
      end
      bus.s_valid = 1'b0;
      step(e);
      n_vec++;
      if (o_fault_count !== 32'd2) begin
         n_miss++;
         $display("FAIL period_count: got %0d, want 2", o_fault_count);
      end
   endtask

   task automatic test_wrap();
      exp_t e;
      en = 1'b1; mode = 2'd2; period = '0; bus.m_ready = 1'b1;
      bus.s_valid = 1'b1; bus.s_data = '0; lfsr = 32'h0000_001F;
      step(e);
      n_vec++;
      if ({bus.m_fault, bus.m_data} !== {1'b1, 32'h8000_0001}) begin
         n_miss++;
         $display("FAIL wrap_double: got f=%b d=%h, want f=1 d=80000001", bus.m_fault, bus.m_data);
      end
      mode = 2'd3; bus.s_data = 32'hFFFF_FFFF; lfsr = 32'hA5A5_A5A5;
      step(e);
      n_vec++;
      if ({bus.m_fault, bus.m_data} !== {1'b1, 32'h5A5A_5A5A}) begin
         n_miss++;
         $display("FAIL full_mask: got f=%b d=%h, want f=1 d=5a5a5a5a", bus.m_fault, bus.m_data);
      end
      bus.s_valid = 1'b0;
      step(e);
   endtask

   task automatic test_backpressure();
      exp_t        e;
      logic [31:0] held_d;
      logic        held_f;
      en = 1'b1; mode = 2'd1; period = 16'd1; bus.m_ready = 1'b1;
      bus.s_valid = 1'b1; bus.s_data = $urandom; lfsr = $urandom;
      step(e);
      held_d = bus.m_data; held_f = bus.m_fault;
      for (int k = 0; k < 3; k++) begin
         bus.m_ready = 1'b0; bus.s_valid = 1'b1; bus.s_data = $urandom; lfsr = $urandom;
         step(e);
         n_vec++;
         if ({e.rdy_got, bus.m_valid, bus.m_fault, bus.m_data} !== {1'b0, 1'b1, held_f, held_d}) begin
            n_miss++;
            $display("FAIL stall[%0d]: got rdy=%b v=%b f=%b d=%h, want rdy=0 v=1 f=%b d=%h",
                     k, e.rdy_got, bus.m_valid, bus.m_fault, bus.m_data, held_f, held_d);
         end
      end
      for (int k = 0; k < 5; k++) begin
         bus.m_ready = 1'b1; bus.s_valid = (k < 3); bus.s_data = $urandom; lfsr = $urandom;
         step(e);
         n_vec++;
         if ({e.rdy_got, bus.m_valid, bus.m_fault, bus.m_data, o_fault_count} !==
             {e.rdy_exp, e.v, e.f, e.d, e.fc}) begin
            n_miss++;
            $display("FAIL release[%0d]: got rdy=%b v=%b f=%b d=%h cnt=%h, want rdy=%b v=%b f=%b d=%h cnt=%h",
                     k, e.rdy_got, bus.m_valid, bus.m_fault, bus.m_data, o_fault_count,
                     e.rdy_exp, e.v, e.f, e.d, e.fc);
         end
      end
   endtask

   task automatic test_random();
      exp_t e;
      for (int k = 0; k < 400; k++) begin
         bus.s_valid = ($urandom_range(0, 3) != 0);
         bus.m_ready = ($urandom_range(0, 3) != 0);
         bus.s_data  = $urandom;
         lfsr        = $urandom;
         if ($urandom_range(0, 15) == 0) begin
            en     = 1'($urandom_range(0, 1));
            mode   = 2'($urandom_range(0, 3));
            period = PERIOD_W'($urandom_range(0, 3));
         end
         oneshot = HAS_OS && ($urandom_range(0, 19) == 0);
         step(e);
         n_vec++;
         if ({e.rdy_got, bus.m_valid, bus.m_fault, bus.m_data, o_fault_count} !==
             {e.rdy_exp, e.v, e.f, e.d, e.fc}) begin
            n_miss++;
            $display("FAIL random[%0d]: got rdy=%b v=%b f=%b d=%h cnt=%h, want rdy=%b v=%b f=%b d=%h cnt=%h",
                     k, e.rdy_got, bus.m_valid, bus.m_fault, bus.m_data, o_fault_count,
                     e.rdy_exp, e.v, e.f, e.d, e.fc);
         end
      end
      oneshot = 1'b0;
      bus.s_valid = 1'b0; bus.m_ready = 1'b1;
      step(e);
   endtask

   task automatic test_saturation();
      exp_t e;
      en = 1'b1; mode = 2'd1; period = '0; bus.m_ready = 1'b1; bus.s_valid = 1'b0;
      step(e);
      force dut.r_fault_count = 32'hFFFF_FFFE;
      fc = 32'hFFFF_FFFE;
      step(e);
      release dut.r_fault_count;
      for (int k = 0; k < 3; k++) begin
         bus.s_valid = 1'b1; bus.s_data = $urandom; lfsr = $urandom;
         step(e);
         n_vec++;
         if ({bus.m_fault, bus.m_data, o_fault_count} !== {e.f, e.d, e.fc}) begin
            n_miss++;
            $display("FAIL saturate[%0d]: got f=%b d=%h cnt=%h, want f=%b d=%h cnt=%h",
                     k, bus.m_fault, bus.m_data, o_fault_count, e.f, e.d, e.fc);
         end
      end
      bus.s_valid = 1'b0;
      step(e);
      n_vec++;
      if (o_fault_count !== 32'hFFFF_FFFF) begin
         n_miss++;
         $display("FAIL saturate_final: got %h, want ffffffff", o_fault_count);
      end
   endtask

   task automatic test_oneshot();
      exp_t e;
      int   n_faults;
      n_faults = 0;
      en = 1'b0; mode = 2'd1; period = '0; bus.m_ready = 1'b1;
      bus.s_valid = 1'b0; oneshot = 1'b1;
      step(e);
      oneshot = 1'b0;
      for (int k = 0; k < 4; k++) begin
         bus.s_valid = 1'b1; bus.s_data = $urandom; lfsr = $urandom;
         step(e);
         if (bus.m_fault === 1'b1) n_faults++;
         n_vec++;
         if ({bus.m_fault, bus.m_data} !== {e.f, e.d}) begin
            n_miss++;
            $display("FAIL oneshot[%0d]: got f=%b d=%h, want f=%b d=%h", k, bus.m_fault, bus.m_data, e.f, e.d);
         end
      end
      bus.s_valid = 1'b0;
      step(e);
      n_vec++;
      if (n_faults != 1) begin
         n_miss++;
         $display("FAIL oneshot_count: got %0d corrupted beats, want 1", n_faults);
      end
   endtask

   initial begin
      bus.s_valid = 1'b0;
      bus.s_data  = '0;
      bus.m_ready = 1'b1;
      @(negedge clk);
      test_reset();
      test_passthrough();
      test_period();
      test_wrap();
      test_backpressure();
      test_random();
      test_saturation();
      if (HAS_OS) test_oneshot();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
